rib_uart_slave: RTL and testbench

- Memory-mapped UART peripheral that sits as a slave port on the RIB bus, the responder side of the master-driven memory protocol.
- Core and debug masters read and write its registers through the slave interface (addr/data/we).
- Serialises bytes on tx_pin and deserialises bytes from rx_pin, 8N1, LSB first, idle high.
- Raises an interrupt line for the core's interrupt bus when a byte is received.

---
 rtl/rib_uart_slave.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rib_uart_slave.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rib_uart_slave.sv
`default_nettype none
// ============================================================================
// rib_uart_slave : RIB memory-mapped 8N1 UART with rx interrupt
// Revision 1.0
// ============================================================================
module rib_uart_slave #(
   parameter logic [15:0] BAUD_DIV_RST = 16'd434,
   parameter logic [15:0] BAUD_DIV_MIN = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        tx_pin,
   input  logic        rx_pin,
   output logic        int_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [7:0] C_A_CTRL   = 8'h00;
   localparam logic [7:0] C_A_STATUS = 8'h04;
   localparam logic [7:0] C_A_BAUD   = 8'h08;
   localparam logic [7:0] C_A_TXDATA = 8'h0C;
   localparam logic [7:0] C_A_RXDATA = 8'h10;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] baud_q, baud_d;
   logic [7:0]  rxdata_q, rxdata_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_overrun_q, rx_overrun_d;
   logic        frame_err_q, frame_err_d;
   logic        int_q, int_d;

   logic [1:0]  tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] tx_baud_q, tx_baud_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_pin_q, tx_pin_d;

   logic [1:0]  rx_sync_q;
   logic        rx_prev_q;
   logic [1:0]  rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [15:0] rx_baud_q, rx_baud_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [2:0]  rx_bit_q, rx_bit_d;

   logic w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_txdata;
   logic w_tx_busy, w_tx_bit_end, w_tx_accept;
   logic w_rx_s, w_rx_fall, w_rx_bit_end, w_rx_half_end;
   logic w_rx_ok, w_rx_err;
   logic w_unused;

   assign w_unused    = ^{addr_i[31:8], data_i[31:16]};

   assign w_wr_ctrl   = we_i && (addr_i[7:0] == C_A_CTRL);
   assign w_wr_status = we_i && (addr_i[7:0] == C_A_STATUS);
   assign w_wr_baud   = we_i && (addr_i[7:0] == C_A_BAUD);
   assign w_wr_txdata = we_i && (addr_i[7:0] == C_A_TXDATA);

   // ------------------------------------------------------------------ TX
   assign w_tx_busy    = (tx_state_q != ST_IDLE);
   assign w_tx_bit_end = (tx_cnt_q == tx_baud_q - 16'd1);
   // The edge that ends the stop bit is also free to accept the next byte.
   assign w_tx_accept  = w_wr_txdata && ctrl_q[0] &&
                         (!w_tx_busy || ((tx_state_q == ST_STOP) && w_tx_bit_end));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_baud_d  = tx_baud_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_pin_d   = tx_pin_q;
      if (w_tx_accept) begin
         tx_state_d = ST_START;
         tx_cnt_d   = 16'd0;
         tx_baud_d  = baud_q;
         tx_shift_d = data_i[7:0];
         tx_pin_d   = 1'b0;
      end else begin
         case (tx_state_q)
            ST_START: begin
               if (w_tx_bit_end) begin
                  tx_state_d = ST_DATA;
                  tx_cnt_d   = 16'd0;
                  tx_bit_d   = 3'd0;
                  tx_pin_d   = tx_shift_q[0];
               end else begin
                  tx_cnt_d = tx_cnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (w_tx_bit_end) begin
                  tx_cnt_d = 16'd0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = ST_STOP;
                     tx_pin_d   = 1'b1;
                  end else begin
                     tx_bit_d   = tx_bit_q + 3'd1;
                     tx_shift_d = {1'b0, tx_shift_q[7:1]};
                     tx_pin_d   = tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q + 16'd1;
               end
            end
            ST_STOP: begin
               if (w_tx_bit_end) begin
                  tx_state_d = ST_IDLE;
                  tx_cnt_d   = 16'd0;
               end else begin
                  tx_cnt_d = tx_cnt_q + 16'd1;
               end
            end
            default: tx_pin_d = 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------------------ RX
   assign w_rx_s        = rx_sync_q[1];
   assign w_rx_fall     = rx_prev_q & ~w_rx_s;
   assign w_rx_bit_end  = (rx_cnt_q == rx_baud_q - 16'd1);
   assign w_rx_half_end = (rx_cnt_q == (rx_baud_q >> 1) - 16'd1);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_baud_d  = rx_baud_q;
      rx_shift_d = rx_shift_q;
      rx_bit_d   = rx_bit_q;
      w_rx_ok    = 1'b0;
      w_rx_err   = 1'b0;
      if (!ctrl_q[1]) begin
         rx_state_d = ST_IDLE;
         rx_cnt_d   = 16'd0;
      end else begin
         case (rx_state_q)
            ST_IDLE: begin
               if (w_rx_fall) begin
                  rx_state_d = ST_START;
                  rx_cnt_d   = 16'd0;
                  rx_baud_d  = baud_q;
               end
            end
            ST_START: begin
               if (w_rx_half_end) begin
                  rx_cnt_d   = 16'd0;
                  rx_bit_d   = 3'd0;
                  rx_state_d = w_rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (w_rx_bit_end) begin
                  rx_cnt_d   = 16'd0;
                  rx_shift_d = {w_rx_s, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                  else                  rx_bit_d   = rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q + 16'd1;
               end
            end
            default: begin
               if (w_rx_bit_end) begin
                  rx_state_d = ST_IDLE;
                  rx_cnt_d   = 16'd0;
                  w_rx_ok    = w_rx_s;
                  w_rx_err   = ~w_rx_s;
               end else begin
                  rx_cnt_d = rx_cnt_q + 16'd1;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------- registers
   // Set terms are OR'd after the W1C mask so a same-edge set wins.
   always_comb begin
      ctrl_d       = w_wr_ctrl ? data_i[2:0] : ctrl_q;
      baud_d       = (w_wr_baud && (data_i[15:0] >= BAUD_DIV_MIN)) ? data_i[15:0] : baud_q;
      rxdata_d     = w_rx_ok ? rx_shift_q : rxdata_q;
      rx_valid_d   = (rx_valid_q   & ~(w_wr_status & data_i[1])) | w_rx_ok;
      rx_overrun_d = (rx_overrun_q & ~(w_wr_status & data_i[2])) | (w_rx_ok & rx_valid_q);
      frame_err_d  = (frame_err_q  & ~(w_wr_status & data_i[3])) | w_rx_err;
      int_d        = rx_valid_q & ctrl_q[2];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q       <= 3'd0;
         baud_q       <= BAUD_DIV_RST;
         rxdata_q     <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         frame_err_q  <= 1'b0;
         int_q        <= 1'b0;
         tx_state_q   <= ST_IDLE;
         tx_cnt_q     <= 16'd0;
         tx_baud_q    <= BAUD_DIV_RST;
         tx_shift_q   <= 8'd0;
         tx_bit_q     <= 3'd0;
         tx_pin_q     <= 1'b1;
         rx_sync_q    <= 2'b11;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= ST_IDLE;
         rx_cnt_q     <= 16'd0;
         rx_baud_q    <= BAUD_DIV_RST;
         rx_shift_q   <= 8'd0;
         rx_bit_q     <= 3'd0;
      end else begin
         ctrl_q       <= ctrl_d;
         baud_q       <= baud_d;
         rxdata_q     <= rxdata_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
         frame_err_q  <= frame_err_d;
         int_q        <= int_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_baud_q    <= tx_baud_d;
         tx_shift_q   <= tx_shift_d;
         tx_bit_q     <= tx_bit_d;
         tx_pin_q     <= tx_pin_d;
         rx_sync_q    <= {rx_sync_q[0], rx_pin};
         rx_prev_q    <= w_rx_s;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_baud_q    <= rx_baud_d;
         rx_shift_q   <= rx_shift_d;
         rx_bit_q     <= rx_bit_d;
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (addr_i[7:0])
         C_A_CTRL:   data_o = {29'd0, ctrl_q};
         C_A_STATUS: data_o = {28'd0, frame_err_q, rx_overrun_q, rx_valid_q, w_tx_busy};
         C_A_BAUD:   data_o = {16'd0, baud_q};
         C_A_RXDATA: data_o = {24'd0, rxdata_q};
         default:    data_o = 32'd0;
      endcase
   end

   assign tx_pin = tx_pin_q;
   assign int_o  = int_q;

endmodule
`default_nettype wire

// File: tb/tb_rib_uart_slave.sv
`default_nettype none
// ============================================================================
// tb_rib_uart_slave : directed self-checking bench for rib_uart_slave
// Revision 1.0
// ============================================================================
module tb_rib_uart_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] data_i = 32'd0;
   logic [31:0] data_o;
   logic        tx_pin;
   logic        rx_pin = 1'b1;
   logic        int_o;

   int n_err = 0;
   int n_chk = 0;
   logic [9:0] pat;

   rib_uart_slave dut (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o),
      .tx_pin (tx_pin),
      .rx_pin (rx_pin),
      .int_o  (int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
      addr_i = {24'd0, a};
      #1;
      chk(tag, data_o, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      we_i   = 1'b1;
      addr_i = {24'd0, a};
      data_i = d;
      @(posedge clk);
      #1 we_i = 1'b0;
   endtask

   // One 8N1 frame at 16 clk/bit; w1c_at >= 0 issues a STATUS rx_valid W1C
   // write sampled on the stop-sample edge when w1c_at = 154.
   task automatic send(input logic [7:0] b, input logic stop, input int w1c_at);
      for (int c = 0; c < 170; c++) begin
         @(negedge clk);
         if (c < 16)       rx_pin = 1'b0;
         else if (c < 144) rx_pin = b[c/16-1];
         else if (c < 160) rx_pin = stop;
         else              rx_pin = 1'b1;
         if (c == w1c_at) begin
            we_i = 1'b1; addr_i = 32'h4; data_i = 32'h2;
         end else if (c == w1c_at + 1) begin
            we_i = 1'b0;
         end
      end
      rx_pin = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
      chk("rst_int", {31'd0, int_o}, 32'd0);
      chk_reg("rst_ctrl", 8'h00, 32'h0);
      chk_reg("rst_status", 8'h04, 32'h0);
      chk_reg("rst_baud", 8'h08, 32'h1B2);
      chk_reg("rst_rxdata", 8'h10, 32'h0);

      // TX 0xA5 at 16 clk/bit, with a dropped write and a rejected BAUD
      wr(8'h08, 32'd16);
      wr(8'h00, 32'h1);
      wr(8'h0C, 32'hA5);
      pat = {1'b1, 8'hA5, 1'b0};
      addr_i = 32'h4;
      for (int c = 1; c <= 165; c++) begin
         @(posedge clk);
         #1;
         if (c == 20) begin we_i = 1'b1; addr_i = 32'hC; data_i = 32'h11; end
         if (c == 21) begin we_i = 1'b0; addr_i = 32'h4; end
         if (c == 30) begin we_i = 1'b1; addr_i = 32'h8; data_i = 32'h3; end
         if (c == 31) begin we_i = 1'b0; addr_i = 32'h4; end
         if ((c % 16 == 8) && (c / 16 < 10))
            chk($sformatf("tx_bit%0d", c/16), {31'd0, tx_pin}, {31'd0, pat[c/16]});
         if (c == 159) chk("tx_busy_at_159", {31'd0, data_o[0]}, 32'd1);
         if (c == 160) chk("tx_busy_at_160", {31'd0, data_o[0]}, 32'd0);
         if (c == 165) chk("tx_idle_pin", {31'd0, tx_pin}, 32'd1);
      end
      chk_reg("baud_min_reject", 8'h08, 32'd16);
      chk_reg("txdata_reads0", 8'h0C, 32'h0);

      // RX
      wr(8'h00, 32'h7);
      send(8'h3C, 1'b1, -1);
      chk_reg("rx1_data", 8'h10, 32'h3C);
      chk_reg("rx1_status", 8'h04, 32'h2);
      chk("rx1_int", {31'd0, int_o}, 32'd1);
      send(8'h55, 1'b1, -1);
      chk_reg("rx2_data", 8'h10, 32'h55);
      chk_reg("rx2_status_overrun", 8'h04, 32'h6);
      wr(8'h04, 32'h6);
      chk_reg("w1c_status", 8'h04, 32'h0);
      chk("w1c_int_lag", {31'd0, int_o}, 32'd1);
      @(posedge clk);
      #1;
      chk("w1c_int_clear", {31'd0, int_o}, 32'd0);

      send(8'h81, 1'b0, -1);
      chk_reg("ferr_status", 8'h04, 32'h8);
      chk_reg("ferr_data_kept", 8'h10, 32'h55);
      wr(8'h04, 32'h8);

      @(negedge clk) rx_pin = 1'b0;
      repeat (5) @(negedge clk);
      rx_pin = 1'b1;
      repeat (30) @(negedge clk);
      chk_reg("glitch_status", 8'h04, 32'h0);
      send(8'h96, 1'b1, -1);
      chk_reg("post_glitch_data", 8'h10, 32'h96);
      chk_reg("post_glitch_status", 8'h04, 32'h2);
      wr(8'h04, 32'hE);

      send(8'hC3, 1'b1, 154);
      chk_reg("set_wins_status", 8'h04, 32'h2);
      chk_reg("set_wins_data", 8'h10, 32'hC3);

      // Reset in the middle of a TX frame
      wr(8'h0C, 32'h00);
      repeat (20) @(posedge clk);
      #1;
      chk("tx_midframe", {31'd0, tx_pin}, 32'd0);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("rst_async_tx_pin", {31'd0, tx_pin}, 32'd1);
      chk("rst_async_int", {31'd0, int_o}, 32'd0);
      @(negedge clk) rst = 1'b1;
      chk_reg("rst2_ctrl", 8'h00, 32'h0);
      chk_reg("rst2_status", 8'h04, 32'h0);
      chk_reg("rst2_baud", 8'h08, 32'h1B2);
      chk_reg("rst2_rxdata", 8'h10, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
